// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment frame sequencer: segment lookup,
// TM1637-style command bytes and the sequencer state encoding.
package seg7_pkg;

    localparam logic [7:0] TM_CMD_DATA = 8'h40;
    localparam logic [7:0] TM_CMD_ADDR = 8'hC0;
    localparam logic [7:0] TM_CMD_CTRL = 8'h80;

    // bit0 = segment a ... bit6 = segment g; bit7 (DP) is added by the encoder
    localparam logic [7:0] seg_lut [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT_DONE,
        ST_WAIT_IDLE,
        ST_FINISH
    } seq_state_t;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational hex-nibble to segment-byte lookup with decimal point and an
// optional blanking input for suppressed leading zeros.
module seg7_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    logic [7:0] lut_val;

    assign lut_val = seg_lut[nibble_i];
    assign seg_o   = {dp_i, blank_i ? 7'h00 : lut_val[6:0]};

endmodule

// File: rtl/seg7_frame_sequencer.sv
// Builds and issues the three-transaction TM1637 display frame through an I2C-style master.
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_frame_sequencer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_RETRY  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    update_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_mask_i,
    input  logic [2:0]              brightness_i,
    input  logic                    display_on_i,
    output logic                    i2c_start_o,
    output logic [7:0]              i2c_data_o [0:7],
    output logic [2:0]              i2c_num_bytes_o,
    input  logic                    i2c_busy_i,
    input  logic                    i2c_done_i,
    input  logic                    i2c_ack_error_i,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    frame_error_o
);

    seq_state_t state_q, state_d;
    logic                    pending_q, pending_d;
    logic [1:0]              step_q, step_d;
    logic [1:0]              retry_q, retry_d;
    logic                    restart_q, restart_d;
    logic                    err_q, err_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic [2:0]              bright_q;
    logic                    on_q;
    logic                    load_snap, load_kick;
    logic [NUM_DIGITS-1:0]   blank;
    logic [7:0]              seg [NUM_DIGITS];
    logic [7:0]              frame_bytes [0:7];
    logic [2:0]              frame_num;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Blank from the most significant digit down until the first nonzero nibble.
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lz_run   = lz_run && (digits_q[4*k +: 4] == 4'h0);
            blank[k] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
        seg7_encoder u_enc (
            .nibble_i (digits_q[4*k +: 4]),
            .dp_i     (dp_q[k]),
            .blank_i  (blank[k]),
            .seg_o    (seg[k])
        );
    end

    always_comb begin
        for (int i = 0; i < 8; i++) frame_bytes[i] = 8'h00;
        frame_num = 3'd1;
        case (step_d)
            2'd0: frame_bytes[0] = TM_CMD_DATA;
            2'd1: begin
                frame_bytes[0] = TM_CMD_ADDR;
                for (int k = 0; k < NUM_DIGITS; k++) frame_bytes[k+1] = seg[k];
                frame_num = 3'(NUM_DIGITS + 1);
            end
            default: frame_bytes[0] = TM_CMD_CTRL | {4'd0, on_q, bright_q};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        retry_d   = retry_q;
        restart_d = restart_q;
        err_d     = err_q;
        load_snap = 1'b0;
        load_kick = 1'b0;
        case (state_q)
            ST_IDLE: if (pending_q) begin
                state_d   = ST_LOAD;
                load_snap = 1'b1;
            end
            ST_LOAD: begin
                step_d    = 2'd0;
                retry_d   = 2'd0;
                restart_d = 1'b0;
                err_d     = 1'b0;
                state_d   = ST_KICK;
                load_kick = 1'b1;
            end
            ST_KICK: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (i2c_done_i) begin
                if (!i2c_ack_error_i) begin
                    state_d = ST_WAIT_IDLE;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    retry_d   = retry_q + 2'd1;
                    step_d    = 2'd0;
                    restart_d = 1'b1;
                    state_d   = ST_WAIT_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            // restart_q marks that step_q was already rewound to 0 after an ACK error
            ST_WAIT_IDLE: if (!i2c_busy_i) begin
                if (restart_q) begin
                    restart_d = 1'b0;
                    state_d   = ST_KICK;
                    load_kick = 1'b1;
                end else if (step_q == 2'd2) begin
                    state_d = ST_FINISH;
                end else begin
                    step_d    = step_q + 2'd1;
                    state_d   = ST_KICK;
                    load_kick = 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign pending_d = update_i | (pending_q & ~load_snap);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_IDLE;
            pending_q       <= 1'b0;
            step_q          <= 2'd0;
            retry_q         <= 2'd0;
            restart_q       <= 1'b0;
            err_q           <= 1'b0;
            digits_q        <= '0;
            dp_q            <= '0;
            bright_q        <= '0;
            on_q            <= 1'b0;
            i2c_num_bytes_o <= '0;
            for (int i = 0; i < 8; i++) i2c_data_o[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            step_q    <= step_d;
            retry_q   <= retry_d;
            restart_q <= restart_d;
            err_q     <= err_d;
            if (load_snap) begin
                digits_q <= digits_i;
                dp_q     <= dp_mask_i;
                bright_q <= brightness_i;
                on_q     <= display_on_i;
            end
            if (load_kick) begin
                i2c_num_bytes_o <= frame_num;
                for (int i = 0; i < 8; i++) i2c_data_o[i] <= frame_bytes[i];
            end
        end
    end

    assign i2c_start_o   = (state_q == ST_KICK);
    assign busy_o        = (state_q != ST_IDLE) || pending_q;
    assign frame_done_o  = (state_q == ST_FINISH);
    assign frame_error_o = (state_q == ST_FINISH) && err_q;

endmodule

// File: tb/tb_seg7_frame_sequencer.sv
// Scoreboard bench for seg7_frame_sequencer: a frame-level reference model queues the
// expected transactions and frame results, a monitor compares them as the DUT emits them.
module tb_seg7_frame_sequencer;

    localparam int ND = 4;
    localparam int MR = 1;

    typedef struct packed {
        logic [2:0]  num;
        logic [63:0] bytes;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n, update, display_on;
    logic [15:0]   digits;
    logic [3:0]    dp_mask;
    logic [2:0]    brightness;
    logic          i2c_start, i2c_busy, i2c_done, i2c_ack_error;
    logic [7:0]    i2c_data [0:7];
    logic [2:0]    i2c_num_bytes;
    logic          busy, frame_done, frame_error;

    txn_t expq[$];
    int   ackq[$];
    bit   resq[$];
    int   nvec = 0, nfail = 0, nstarts = 0;
    bit   stab_chk = 0, m_release = 0;
    txn_t last_txn;

    always #5 clk = ~clk;

    seg7_frame_sequencer #(.NUM_DIGITS(ND), .MAX_RETRY(MR)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .update_i        (update),
        .digits_i        (digits),
        .dp_mask_i       (dp_mask),
        .brightness_i    (brightness),
        .display_on_i    (display_on),
        .i2c_start_o     (i2c_start),
        .i2c_data_o      (i2c_data),
        .i2c_num_bytes_o (i2c_num_bytes),
        .i2c_busy_i      (i2c_busy),
        .i2c_done_i      (i2c_done),
        .i2c_ack_error_i (i2c_ack_error),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .frame_error_o   (frame_error)
    );

    function automatic logic [7:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    function automatic txn_t dut_txn();
        txn_t t;
        t.num = i2c_num_bytes;
        for (int i = 0; i < 8; i++) t.bytes[8*i +: 8] = i2c_data[i];
        return t;
    endfunction

    // Frame model: fail bit (attempt*3 + step) makes that transaction's ACK fail.
    task automatic plan_frame(input logic [15:0] dg, input logic [3:0] dp, input logic [2:0] br,
                              input logic on, input logic [11:0] fail);
        txn_t        t;
        logic [63:0] digit_bytes;
        logic [7:0]  b;
        logic [3:0]  nib;
        bit          ok = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        bit          lead = 1;
`endif
        digit_bytes = 64'hC0;
        for (int k = ND - 1; k >= 0; k--) begin
            nib = dg[4*k +: 4];
            b   = ref_seg(nib);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lead = lead && (nib == 4'h0) && (k != 0);
            if (lead) b = 8'h00;
`endif
            b[7] = dp[k];
            digit_bytes[8*(k+1) +: 8] = b;
        end
        for (int a = 0; a <= MR && !ok; a++) begin
            for (int s = 0; s < 3; s++) begin
                t.num   = (s == 1) ? 3'(ND + 1) : 3'd1;
                t.bytes = (s == 0) ? 64'h40 : (s == 1) ? digit_bytes : {56'd0, 8'h80 | {4'd0, on, br}};
                expq.push_back(t);
                if (fail[a*3 + s]) begin
                    ackq.push_back(1);
                    break;
                end
                ackq.push_back(0);
                if (s == 2) ok = 1;
            end
        end
        resq.push_back(!ok);
    endtask

    // I2C master model: ackq entry 0 = ACK, 1 = ACK error, 2 = hang until m_release.
    initial begin
        int f;
        i2c_busy = 0; i2c_done = 0; i2c_ack_error = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && i2c_start) begin
                f = (ackq.size() != 0) ? ackq.pop_front() : 0;
                i2c_busy = 1;
                if (f == 2) begin
                    for (int i = 0; i < 3000 && !m_release; i++) begin @(posedge clk); #1; end
                end else begin
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                end
                i2c_done = 1; i2c_ack_error = (f == 1);
                @(posedge clk); #1;
                i2c_done = 0; i2c_ack_error = 0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                i2c_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        txn_t got, exp_t;
        if (!rst_n) begin
            stab_chk = 0;
        end else begin
            if (i2c_start) begin
                nstarts++;
                nvec++;
                got = dut_txn();
                if (expq.size() == 0) begin
                    nfail++;
                    $display("FAIL start_unexpected: got n=%0d data=%h, required no start", got.num, got.bytes);
                end else begin
                    exp_t = expq.pop_front();
                    if (got !== exp_t) begin
                        nfail++;
                        $display("FAIL txn: got n=%0d data=%h, required n=%0d data=%h",
                                 got.num, got.bytes, exp_t.num, exp_t.bytes);
                    end
                end
                last_txn = got;
                stab_chk = 1;
            end
            if (i2c_done && stab_chk) begin
                nvec++;
                got = dut_txn();
                if (got !== last_txn) begin
                    nfail++;
                    $display("FAIL data_stable: got n=%0d data=%h, required n=%0d data=%h",
                             got.num, got.bytes, last_txn.num, last_txn.bytes);
                end
                stab_chk = 0;
            end
            if (frame_done || frame_error) begin
                nvec++;
                if (!frame_done) begin
                    nfail++;
                    $display("FAIL frame_error_alone: frame_error=1 with frame_done=0, required coincident");
                end else if (resq.size() == 0) begin
                    nfail++;
                    $display("FAIL frame_done_unexpected: got frame_done=1, required none");
                end else begin
                    bit e;
                    e = resq.pop_front();
                    if (frame_error !== e) begin
                        nfail++;
                        $display("FAIL frame_error: got %0b, required %0b", frame_error, e);
                    end
                end
            end
        end
    end

    task automatic apply(input logic [15:0] dg, input logic [3:0] dp, input logic [2:0] br,
                         input logic on, input logic [11:0] fail);
        @(posedge clk); #1;
        digits = dg; dp_mask = dp; brightness = br; display_on = on;
        plan_frame(dg, dp, br, on, fail);
        update = 1;
        @(posedge clk); #1;
        update = 0;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !i2c_busy && expq.size() == 0 && resq.size() == 0) ok = 1;
        end
        if (!ok) begin
            nvec++;
            nfail++;
            $display("FAIL idle_timeout: got busy=%0b pending_txns=%0d pending_frames=%0d, required idle",
                     busy, expq.size(), resq.size());
            expq.delete(); ackq.delete(); resq.delete();
        end
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 2000 && nstarts < target; i++) @(negedge clk);
        if (nstarts < target) begin
            nvec++;
            nfail++;
            $display("FAIL start_timeout: got %0d starts, required %0d", nstarts, target);
        end
    endtask

    task automatic check_zero(input string name);
        txn_t t;
        t = dut_txn();
        nvec++;
        if ({i2c_start, busy, frame_done, frame_error} !== 4'b0 || t !== '0) begin
            nfail++;
            $display("FAIL %s: got start=%0b busy=%0b done=%0b err=%0b n=%0d data=%h, required all 0",
                     name, i2c_start, busy, frame_done, frame_error, t.num, t.bytes);
        end
    endtask

    initial begin
        int s0;
        rst_n = 0; update = 0; digits = '0; dp_mask = '0; brightness = '0; display_on = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check_zero("reset_state");

        apply(16'h1234, 4'b0000, 3'd7, 1'b1, 12'h000);
        wait_idle();

        // Two updates during a frame collapse into one further frame with the new digits.
        s0 = nstarts;
        apply(16'h5678, 4'b0000, 3'd2, 1'b1, 12'h000);
        wait_starts(s0 + 1);
        @(posedge clk); #1;
        digits = 16'hABCD; dp_mask = 4'b0000; brightness = 3'd5; display_on = 1'b0;
        plan_frame(16'hABCD, 4'b0000, 3'd5, 1'b0, 12'h000);
        update = 1; @(posedge clk); #1; update = 0;
        @(posedge clk); #1;
        update = 1; @(posedge clk); #1; update = 0;
        wait_idle();

        apply(16'h9F0E, 4'b1000, 3'd3, 1'b1, 12'h002);
        wait_idle();
        apply(16'h4321, 4'b0011, 3'd1, 1'b1, 12'h00C);
        wait_idle();
        apply(16'h8888, 4'b0101, 3'd0, 1'b1, 12'h000);
        wait_idle();
        apply(16'h0040, 4'b0000, 3'd4, 1'b1, 12'h000);
        wait_idle();
        apply(16'h0000, 4'b0010, 3'd4, 1'b1, 12'h000);
        wait_idle();

        // Reset while waiting for the address/digit transaction to complete.
        s0 = nstarts;
        apply(16'h2468, 4'b0000, 3'd6, 1'b1, 12'h000);
        void'(expq.pop_back());
        void'(ackq.pop_back());
        void'(ackq.pop_back());
        ackq.push_back(2);
        void'(resq.pop_back());
        wait_starts(s0 + 2);
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        check_zero("reset_mid_frame");
        m_release = 1;
        repeat (15) @(negedge clk);
        m_release = 0;
        nvec++;
        if (nstarts != s0 + 2 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL late_done: got starts=%0d busy=%0b, required starts=%0d busy=0",
                     nstarts, busy, s0 + 2);
        end
        apply(16'h1357, 4'b1001, 3'd7, 1'b0, 12'h000);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            logic [11:0] fb;
            fb = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 63)) : 12'h000;
            apply(16'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), fb);
            digits = 16'($urandom); dp_mask = 4'($urandom); brightness = 3'($urandom);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
